// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage operand forwarding / load-use hazard unit.
package fwd_pkg;

    typedef enum logic [1:0] {
        SRC_RF   = 2'd0,
        SRC_HOLD = 2'd1,
        SRC_WB   = 2'd2,
        SRC_MEM  = 2'd3
    } fwd_src_e;

    // Operands per lane ({src1,src0}) and the widest register address addr_hit compares.
    localparam int unsigned NSRC       = 2;
    localparam int unsigned ADDR_MAX_W = 8;

    function automatic int unsigned op_idx(input int unsigned lane, input int unsigned src);
        return lane * NSRC + src;
    endfunction

    function automatic int unsigned op_lane(input int unsigned op);
        return op / NSRC;
    endfunction

    // Register 0 is hardwired, so it never produces a forwarding hit.
    function automatic logic addr_hit(input logic [ADDR_MAX_W-1:0] raddr,
                                      input logic [ADDR_MAX_W-1:0] waddr,
                                      input logic                  we);
        return we && (raddr == waddr) && (raddr != '0);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Priority mux for one EX source operand: MEM (youngest first), WB (youngest first), hold, regfile.
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int unsigned NLANE = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5
) (
    input  logic [AW-1:0]         raddr_i,
    input  logic [XLEN-1:0]       rf_data_i,
    input  logic                  hold_vld_i,
    input  logic [XLEN-1:0]       hold_data_i,
    input  logic [NLANE-1:0]      mem_we_i,
    input  logic [NLANE*AW-1:0]   mem_waddr_i,
    input  logic [NLANE-1:0]      mem_fwd_ok_i,
    input  logic [NLANE*XLEN-1:0] mem_result_i,
    input  logic [NLANE-1:0]      wb_we_i,
    input  logic [NLANE*AW-1:0]   wb_waddr_i,
    input  logic [NLANE*XLEN-1:0] wb_wdata_i,
    output logic [XLEN-1:0]       data_c_o,
    output fwd_src_e              src_c_o,
    output logic                  op_haz_c_o
);

    // Sources are visited lowest to highest priority; within a stage the
    // younger (higher-index) lane is visited later and so overrides.
    always_comb begin
        data_c_o   = rf_data_i;
        src_c_o    = SRC_RF;
        op_haz_c_o = 1'b0;

        if (hold_vld_i) begin
            data_c_o = hold_data_i;
            src_c_o  = SRC_HOLD;
        end

        for (int i = 0; i < int'(NLANE); i++) begin
            if (addr_hit(ADDR_MAX_W'(raddr_i), ADDR_MAX_W'(wb_waddr_i[i*AW +: AW]), wb_we_i[i])) begin
                data_c_o = wb_wdata_i[i*XLEN +: XLEN];
                src_c_o  = SRC_WB;
            end
        end

        // A non-ready youngest MEM producer raises the hazard even if an older lane is ready.
        for (int i = 0; i < int'(NLANE); i++) begin
            if (addr_hit(ADDR_MAX_W'(raddr_i), ADDR_MAX_W'(mem_waddr_i[i*AW +: AW]), mem_we_i[i])) begin
                data_c_o   = mem_result_i[i*XLEN +: XLEN];
                src_c_o    = SRC_MEM;
                op_haz_c_o = ~mem_fwd_ok_i[i];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// N-lane EX operand forwarding with load-use stall detection, freeze-time hold registers
// and a saturating hazard-stall cycle counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NLANE = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNTW  = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       ex_stall_in,
    input  logic [NLANE-1:0]           ex_valid,
    input  logic [NLANE*NSRC*AW-1:0]   ex_raddr,
    input  logic [NLANE*NSRC*XLEN-1:0] ex_rdata,
    input  logic [NLANE-1:0]           mem_we,
    input  logic [NLANE*AW-1:0]        mem_waddr,
    input  logic [NLANE-1:0]           mem_fwd_ok,
    input  logic [NLANE*XLEN-1:0]      mem_alu_result,
    input  logic [NLANE-1:0]           wb_we,
    input  logic [NLANE*AW-1:0]        wb_waddr,
    input  logic [NLANE*XLEN-1:0]      wb_wdata,
    output logic [NLANE*NSRC*XLEN-1:0] ex_rdata_f,
    output logic                       hazard_stall,
    output logic [CNTW-1:0]            stall_cnt
);

    localparam int unsigned NOPS = NLANE * NSRC;

    logic [XLEN-1:0] sel_data   [NOPS];
    fwd_src_e        sel_src    [NOPS];
    logic [NOPS-1:0] op_haz;
    logic [NOPS-1:0] capture_c;
    logic            freeze_c;

    logic [NOPS-1:0] hold_vld_q;
    logic [NOPS-1:0] hold_vld_d;
    logic [XLEN-1:0] hold_data_q [NOPS];
    logic [XLEN-1:0] hold_data_d [NOPS];
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            localparam int unsigned OP = op_idx(l, s);

            fwd_operand_sel #(
                .NLANE (NLANE),
                .XLEN  (XLEN),
                .AW    (AW)
            ) u_sel (
                .raddr_i      (ex_raddr[OP*AW +: AW]),
                .rf_data_i    (ex_rdata[OP*XLEN +: XLEN]),
                .hold_vld_i   (hold_vld_q[OP]),
                .hold_data_i  (hold_data_q[OP]),
                .mem_we_i     (mem_we),
                .mem_waddr_i  (mem_waddr),
                .mem_fwd_ok_i (mem_fwd_ok),
                .mem_result_i (mem_alu_result),
                .wb_we_i      (wb_we),
                .wb_waddr_i   (wb_waddr),
                .wb_wdata_i   (wb_wdata),
                .data_c_o     (sel_data[OP]),
                .src_c_o      (sel_src[OP]),
                .op_haz_c_o   (op_haz[OP])
            );

            assign ex_rdata_f[OP*XLEN +: XLEN] = sel_data[OP];

            // Only values that would otherwise vanish from the pipeline are worth holding.
            assign capture_c[OP] = (sel_src[OP] == SRC_WB) ||
                                   ((sel_src[OP] == SRC_MEM) && !op_haz[OP]);
        end
    end

    // Any valid lane waiting on a non-ready MEM producer freezes the whole EX stage.
    always_comb begin
        hazard_stall = 1'b0;
        for (int g = 0; g < int'(NOPS); g++) begin
            if (ex_valid[op_lane(g)] && op_haz[g]) begin
                hazard_stall = 1'b1;
            end
        end
    end

    assign freeze_c = ex_stall_in | hazard_stall;

    // Hold registers: capture while frozen, drop on thaw; flush beats capture.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        for (int g = 0; g < int'(NOPS); g++) begin
            if (flush || !freeze_c) begin
                hold_vld_d[g] = 1'b0;
            end else if (capture_c[g]) begin
                hold_vld_d[g]  = 1'b1;
                hold_data_d[g] = sel_data[g];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_vld_q  <= '0;
            stall_cnt_q <= '0;
            for (int g = 0; g < int'(NOPS); g++) begin
                hold_data_q[g] <= '0;
            end
        end else begin
            hold_vld_q  <= hold_vld_d;
            stall_cnt_q <= stall_cnt_d;
            for (int g = 0; g < int'(NOPS); g++) begin
                hold_data_q[g] <= hold_data_d[g];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: NLANE=2, XLEN=32, AW=5, 4-bit stall counter.
module tb_fwd_hazard_unit;

    localparam int unsigned NLANE = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNTW  = 4;

    logic                    clk;
    logic                    rstn;
    logic                    flush;
    logic                    ex_stall_in;
    logic [NLANE-1:0]        ex_valid;
    logic [NLANE*2*AW-1:0]   ex_raddr;
    logic [NLANE*2*XLEN-1:0] ex_rdata;
    logic [NLANE-1:0]        mem_we;
    logic [NLANE*AW-1:0]     mem_waddr;
    logic [NLANE-1:0]        mem_fwd_ok;
    logic [NLANE*XLEN-1:0]   mem_alu_result;
    logic [NLANE-1:0]        wb_we;
    logic [NLANE*AW-1:0]     wb_waddr;
    logic [NLANE*XLEN-1:0]   wb_wdata;
    logic [NLANE*2*XLEN-1:0] ex_rdata_f;
    logic                    hazard_stall;
    logic [CNTW-1:0]         stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(
        .NLANE (NLANE),
        .XLEN  (XLEN),
        .AW    (AW),
        .CNTW  (CNTW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .ex_stall_in    (ex_stall_in),
        .ex_valid       (ex_valid),
        .ex_raddr       (ex_raddr),
        .ex_rdata       (ex_rdata),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_fwd_ok     (mem_fwd_ok),
        .mem_alu_result (mem_alu_result),
        .wb_we          (wb_we),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata),
        .ex_rdata_f     (ex_rdata_f),
        .hazard_stall   (hazard_stall),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        flush          = 1'b0;
        ex_stall_in    = 1'b0;
        ex_valid       = '0;
        ex_raddr       = '0;
        ex_rdata       = '0;
        mem_we         = '0;
        mem_waddr      = '0;
        mem_fwd_ok     = '0;
        mem_alu_result = '0;
        wb_we          = '0;
        wb_waddr       = '0;
        wb_wdata       = '0;
    endtask

    task automatic set_op(input int l, input int s, input logic [4:0] a, input logic [31:0] d);
        ex_raddr[(l*2+s)*5 +: 5]   = a;
        ex_rdata[(l*2+s)*32 +: 32] = d;
    endtask

    task automatic set_mem(input int l, input logic we, input logic [4:0] a,
                           input logic ok, input logic [31:0] d);
        mem_we[l]                = we;
        mem_waddr[l*5 +: 5]      = a;
        mem_fwd_ok[l]            = ok;
        mem_alu_result[l*32 +: 32] = d;
    endtask

    task automatic set_wb(input int l, input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we[l]             = we;
        wb_waddr[l*5 +: 5]   = a;
        wb_wdata[l*32 +: 32] = d;
    endtask

    function automatic logic [31:0] op_f(input int l, input int s);
        return ex_rdata_f[(l*2+s)*32 +: 32];
    endfunction

    initial begin
        rstn = 1'b0;
        clear_inputs();
        #2;
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_haz", 32'(hazard_stall), 32'd0);
        check("rst_f00", op_f(0, 0), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // regfile passthrough
        @(negedge clk);
        set_op(0, 0, 5'd1, 32'h1111);
        #1;
        check("rf_pass", op_f(0, 0), 32'h1111);
        check("rf_haz", 32'(hazard_stall), 32'd0);

        // lane priority and MEM over WB
        @(negedge clk);
        clear_inputs();
        set_op(0, 0, 5'd5, 32'h99);
        set_op(1, 1, 5'd5, 32'h98);
        set_mem(0, 1'b1, 5'd5, 1'b1, 32'hA);
        set_mem(1, 1'b1, 5'd5, 1'b1, 32'hB);
        #1;
        check("mem_young_l0", op_f(0, 0), 32'hB);
        check("mem_young_l1", op_f(1, 1), 32'hB);
        @(negedge clk);
        set_mem(1, 1'b0, 5'd5, 1'b1, 32'hB);
        set_wb(0, 1'b1, 5'd5, 32'hC);
        #1;
        check("mem_over_wb", op_f(0, 0), 32'hA);
        @(negedge clk);
        set_mem(0, 1'b0, 5'd5, 1'b1, 32'hA);
        set_wb(1, 1'b1, 5'd5, 32'hD);
        #1;
        check("wb_young", op_f(0, 0), 32'hD);

        // load-use hazard
        @(negedge clk);
        clear_inputs();
        set_op(0, 0, 5'd7, 32'h70);
        set_mem(1, 1'b1, 5'd7, 1'b0, 32'h0);
        ex_valid = 2'b01;
        #1;
        check("lu_haz", 32'(hazard_stall), 32'd1);
        check("lu_cnt0", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        check("lu_cnt1", 32'(stall_cnt), 32'd1);
        @(negedge clk);
        check("lu_cnt2", 32'(stall_cnt), 32'd2);
        set_mem(0, 1'b1, 5'd7, 1'b1, 32'h77);
        #1;
        check("lu_older_ready", 32'(hazard_stall), 32'd1);
        @(negedge clk);
        check("lu_cnt3", 32'(stall_cnt), 32'd3);
        ex_valid = 2'b00;
        #1;
        check("lu_invalid", 32'(hazard_stall), 32'd0);
        ex_valid = 2'b10;
        #1;
        check("lu_other_lane", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        check("lu_cnt_idle", 32'(stall_cnt), 32'd3);
        ex_valid = 2'b01;
        flush    = 1'b1;
        #1;
        check("lu_flush_haz", 32'(hazard_stall), 32'd1);
        @(negedge clk);
        check("lu_flush_cnt", 32'(stall_cnt), 32'd3);

        // hold across an external freeze
        clear_inputs();
        set_op(0, 0, 5'd3, 32'h1234);
        set_wb(0, 1'b1, 5'd3, 32'hDEAD);
        ex_stall_in = 1'b1;
        #1;
        check("hold_wb", op_f(0, 0), 32'hDEAD);
        @(negedge clk);
        set_wb(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("hold_c1", op_f(0, 0), 32'hDEAD);
        @(negedge clk);
        check("hold_c2", op_f(0, 0), 32'hDEAD);
        @(negedge clk);
        ex_stall_in = 1'b0;
        #1;
        check("hold_thaw", op_f(0, 0), 32'hDEAD);
        @(negedge clk);
        check("hold_clear", op_f(0, 0), 32'h1234);

        // r0 never forwards
        clear_inputs();
        set_op(0, 0, 5'd0, 32'h77);
        set_mem(0, 1'b1, 5'd0, 1'b1, 32'h55);
        set_wb(1, 1'b1, 5'd0, 32'h66);
        #1;
        check("r0_pass", op_f(0, 0), 32'h77);

        // flush clears an existing hold
        @(negedge clk);
        clear_inputs();
        set_op(0, 0, 5'd3, 32'h1234);
        set_wb(0, 1'b1, 5'd3, 32'hBEEF);
        ex_stall_in = 1'b1;
        @(negedge clk);
        set_wb(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("flush_pre", op_f(0, 0), 32'hBEEF);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_post", op_f(0, 0), 32'h1234);

        // flush beats a same-edge capture
        @(negedge clk);
        set_wb(0, 1'b1, 5'd3, 32'hCAFE);
        flush = 1'b1;
        @(negedge clk);
        set_wb(0, 1'b0, 5'd0, 32'h0);
        flush = 1'b0;
        #1;
        check("flush_vs_cap", op_f(0, 0), 32'h1234);

        // ready MEM value is captured too
        @(negedge clk);
        set_mem(0, 1'b1, 5'd3, 1'b1, 32'h4444);
        @(negedge clk);
        set_mem(0, 1'b0, 5'd0, 1'b0, 32'h0);
        #1;
        check("hold_mem", op_f(0, 0), 32'h4444);
        ex_stall_in = 1'b0;
        @(negedge clk);
        check("hold_mem_clr", op_f(0, 0), 32'h1234);

        // counter saturation, then async reset mid-stall
        clear_inputs();
        set_op(0, 0, 5'd7, 32'h70);
        set_mem(1, 1'b1, 5'd7, 1'b0, 32'h0);
        ex_valid = 2'b01;
        set_op(1, 0, 5'd3, 32'h0101);
        set_wb(0, 1'b1, 5'd3, 32'h7777);
        repeat (20) @(negedge clk);
        check("sat_cnt", 32'(stall_cnt), 32'd15);
        set_wb(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("sat_hold", op_f(1, 0), 32'h7777);
        @(negedge clk);
        check("sat_nowrap", 32'(stall_cnt), 32'd15);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_cnt", 32'(stall_cnt), 32'd0);
        check("arst_hold", op_f(1, 0), 32'h0101);
        @(negedge clk);
        check("arst_cnt_held", 32'(stall_cnt), 32'd0);
        rstn = 1'b1;
        clear_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
